uart_rx_ctrl: RTL

UART receive controller for the serial link, the counterpart to the UART transmit path.
- Detects the start bit on RX_IN and oversamples each bit with a configurable prescale.
- Majority-votes three samples per bit, deserialises 8 data bits LSB first, checks optional parity and the stop bit.
- Delivers the byte with a one-cycle valid pulse.
- Sits between the RX pin synchroniser and the RX data FIFO/register file. All operation is in the UART oversampled clock domain.

---
 rtl/uart_rx_ctrl_if.sv | 19 +
 rtl/uart_rx_ctrl.sv | 94 +++++++++
 2 files changed

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial line, frame config and received-byte outputs of the UART receiver
interface uart_rx_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic RX_IN;
  logic [5:0] Prescale;
  logic PAR_EN;
  logic PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic data_valid;
  logic par_err;
  logic stp_err;
  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err
  );
  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receiver with 3-sample majority vote, optional parity and stop check
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input logic CLK,
  input logic RST,
  uart_rx_ctrl_if.slave bus
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } state_t;
  state_t state, next;
  logic [5:0] p, edge_cnt, half, p_dec;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] sh, data;
  logic [2:0] smp;
  logic par_en, par_typ, err;
  logic dv, pe, se, dv_n, pe_n, se_n;
  logic bit_end, at_sample, sampled, detect, last;
  assign half      = {1'b0, p[5:1]};
  assign bit_end   = edge_cnt == p - 6'd1;
  assign at_sample = edge_cnt == half - 6'd1 || edge_cnt == half || edge_cnt == half + 6'd1;
  assign sampled   = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign detect    = state == IDLE && !bus.RX_IN;
  assign last      = bit_cnt == BW'(DATA_WIDTH - 1);
  assign p_dec     = (bus.Prescale == 6'd16 || bus.Prescale == 6'd32) ? bus.Prescale : 6'd8;
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = bus.RX_IN ? IDLE : START;
      START:   next = !bit_end ? START : (sampled ? IDLE : DATA);
      DATA:    next = (bit_end && last) ? (par_en ? PARITY : STOP) : DATA;
      PARITY:  next = bit_end ? STOP : PARITY;
      STOP:    next = bit_end ? IDLE : STOP;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    dv_n = state == STOP && bit_end && sampled && !err;
    pe_n = state == PARITY && bit_end && (sampled != (^sh ^ par_typ));
    se_n = state == STOP && bit_end && !sampled;
  end
  // Frame config is frozen at start detection so mid-frame input changes are ignored
  always_ff @(posedge CLK) begin
    if (RST) begin
      p        <= 6'd8;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      smp      <= '0;
      par_en   <= 1'b0;
      par_typ  <= 1'b0;
      err      <= 1'b0;
      data     <= '0;
      dv       <= 1'b0;
      pe       <= 1'b0;
      se       <= 1'b0;
    end else begin
      dv <= dv_n;
      pe <= pe_n;
      se <= se_n;
      if (dv_n) data <= sh;
      if (pe_n) err <= 1'b1;
      if (detect) begin
        p        <= p_dec;
        par_en   <= bus.PAR_EN;
        par_typ  <= bus.PAR_TYP;
        err      <= 1'b0;
        edge_cnt <= 6'd1;
      end else if (state != IDLE) begin
        edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
      end
      if (state != IDLE && at_sample) smp <= {bus.RX_IN, smp[2:1]};
      if (state == START && bit_end) bit_cnt <= '0;
      if (state == DATA && bit_end) begin
        sh      <= {sampled, sh[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
  assign bus.P_DATA     = data;
  assign bus.data_valid = dv;
  assign bus.par_err    = pe;
  assign bus.stp_err    = se;
endmodule
